// File: rtl/serial_full_subtractor_pkg.sv
// Shared definitions for the bit-serial full subtractor: FSM state encoding and
// the default operand width.
package serial_full_subtractor_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_full_subtractor_half_subtractor.sv
// One-bit half subtractor: d = a - b, borrow set when a < b.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic borrow
);

  assign d      = a ^ b;
  assign borrow = ~a & b;

endmodule

// File: rtl/serial_full_subtractor.sv
// Bit-serial full subtractor: computes a_in - b_in - bin one bit per cycle,
// LSB first, collecting the parallel result in diff_out.
module serial_full_subtractor
  import serial_full_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             busy,
  output logic             diff_bit_valid,
  output logic             diff_bit,
  output logic [WIDTH-1:0] diff_out,
  output logic             bout,
  output logic             done,
  output state_t           dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is a request that is accepted only in IDLE (no ready
  // output); done is a one-cycle valid pulse that qualifies diff_out/bout,
  // and diff_bit_valid qualifies diff_bit during RUN.

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             step;
  logic             last_bit;
  logic             d1;
  logic             b1;
  logic             b2;
  logic             d;
  logic             br_next;

  // Full subtractor built from two half subtractors, as a full adder is from two half adders.
  half_subtractor u_hs_ab (
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .d      (d1),
    .borrow (b1)
  );

  half_subtractor u_hs_br (
    .a      (d1),
    .b      (br),
    .d      (d),
    .borrow (b2)
  );

  assign br_next = b1 | b2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    last_bit   = (cnt == LAST);
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      diff_out <= '0;
      bout     <= 1'b0;
    end else if (accept) begin
      a_sr     <= a_in;
      b_sr     <= b_in;
      br       <= bin;
      cnt      <= '0;
      diff_out <= '0;
      bout     <= 1'b0;
    end else if (step) begin
      // Each new bit enters at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
      a_sr     <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
      diff_out <= {d, diff_out[WIDTH-1:1]};
      br       <= br_next;
      cnt      <= cnt + 1'b1;
      if (last_bit) begin
        bout <= br_next;
      end
    end
  end

  // All outputs decode registered state only, so start never reaches an output combinationally.
  assign busy           = (state != IDLE);
  assign diff_bit_valid = (state == RUN);
  assign diff_bit       = diff_bit_valid & d;
  assign done           = (state == DONE);
  assign dbg_state      = state;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Directed and swept checks of serial_full_subtractor at WIDTH=8 and WIDTH=13,
// with serial bits scored against an expected queue.
module tb_serial_full_subtractor;
  import serial_full_subtractor_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a8, b8;
  logic        bin8;
  logic        busy8, dv8, db8, bout8, done8;
  logic [7:0]  diff8;
  state_t      st8;
  logic [12:0] a13, b13;
  logic        bin13;
  logic        busy13, dv13, db13, bout13, done13;
  logic [12:0] diff13;
  state_t      st13;

  int          total = 0;
  int          bad   = 0;
  logic [0:0]  exp_q[$];

  always #5 clk = ~clk;

  serial_full_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .a_in(a8), .b_in(b8), .bin(bin8),
    .busy(busy8), .diff_bit_valid(dv8), .diff_bit(db8), .diff_out(diff8),
    .bout(bout8), .done(done8), .dbg_state(st8)
  );

  serial_full_subtractor #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst(rst), .start(start), .a_in(a13), .b_in(b13), .bin(bin13),
    .busy(busy13), .diff_bit_valid(dv13), .diff_bit(db13), .diff_out(diff13),
    .bout(bout13), .done(done13), .dbg_state(st13)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset8(input string tag);
    check({tag, "_busy"}, busy8, 0);
    check({tag, "_valid"}, dv8, 0);
    check({tag, "_bit"}, db8, 0);
    check({tag, "_diff"}, diff8, 0);
    check({tag, "_bout"}, bout8, 0);
    check({tag, "_done"}, done8, 0);
    check({tag, "_state"}, st8, IDLE);
  endtask

  // One WIDTH=8 operation; start is driven in the current (IDLE) cycle.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input logic [7:0] exp_d, input logic exp_bo,
                     input bit poke_mid, input bit poke_done, input string tag);
    bit seen;
    seen = 0;
    a8 = a; b8 = b; bin8 = bi; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_state_run"}, st8, RUN);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(exp_d[i]);
    for (int c = 1; c <= 12 && !seen; c++) begin
      if (dv8) begin
        if (exp_q.size() == 0) check({tag, "_extra_bit"}, 1, 0);
        else check({tag, "_bit"}, db8, exp_q.pop_front());
      end else begin
        check({tag, "_bit_idle"}, db8, 0);
      end
      if (poke_mid && c == 3) begin
        start = 1'b1; a8 = 8'hA5; b8 = 8'h5A; bin8 = 1'b1;
      end else if (done8) begin
        seen = 1;
        check({tag, "_done_cycle"}, c, 9);
        check({tag, "_diff"}, diff8, exp_d);
        check({tag, "_bout"}, bout8, exp_bo);
        check({tag, "_busy_done"}, busy8, 1);
        if (poke_done) begin
          start = 1'b1; a8 = 8'h77; b8 = 8'h11; bin8 = 1'b0;
        end
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    if (!seen) check({tag, "_done_timeout"}, 0, 1);
    check({tag, "_bits_left"}, exp_q.size(), 0);
    check({tag, "_idle_busy"}, busy8, 0);
    check({tag, "_idle_done"}, done8, 0);
    check({tag, "_hold_diff"}, diff8, exp_d);
    check({tag, "_hold_bout"}, bout8, exp_bo);
  endtask

  initial begin
    logic [8:0]  r8;
    logic [13:0] r13;
    bit          seen8, seen13;

    rst = 1'b1; start = 1'b0;
    a8 = '0; b8 = '0; bin8 = 1'b0;
    a13 = '0; b13 = '0; bin13 = 1'b0;
    tick();
    tick();
    check_reset8("reset");
    check("reset13_busy", busy13, 0);
    rst = 1'b0;
    tick();

    op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 0, 0, "v05_03");
    op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 0, 0, "v03_05");
    op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 0, 0, "v00_00_b1");
    op8(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 0, 0, "vFF_FF");
    op8(8'h80, 8'h01, 1'b1, 8'h7E, 1'b0, 0, 0, "v80_01_b1");

    // Starts during RUN and coincident with done are ignored; the next IDLE start is taken.
    op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1, 1, "ign_start");
    op8(8'h10, 8'h20, 1'b1, 8'hEF, 1'b1, 0, 0, "after_done");

    // Reset on the 4th RUN cycle discards the operation.
    a8 = 8'h5A; b8 = 8'h33; bin8 = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("mid_run_busy", busy8, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset8("mid_rst");
    for (int c = 0; c < 12; c++) begin
      check("mid_rst_no_done", done8, 0);
      tick();
    end

    // Reset wins over a simultaneous start.
    a8 = 8'hC3; b8 = 8'h3C; bin8 = 1'b0; start = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_prio_state", st8, IDLE);
    tick();
    op8(8'h5A, 8'h33, 1'b0, 8'h27, 1'b0, 0, 0, "post_rst");

    for (int c = 0; c < 16; c++) tick();

    for (int n = 0; n < 1000; n++) begin
      a8    = 8'($urandom_range(0, 255));
      b8    = 8'($urandom_range(0, 255));
      bin8  = 1'($urandom_range(0, 1));
      a13   = 13'($urandom_range(0, 8191));
      b13   = 13'($urandom_range(0, 8191));
      bin13 = 1'($urandom_range(0, 1));
      r8    = {1'b0, a8} - {1'b0, b8} - {8'b0, bin8};
      r13   = {1'b0, a13} - {1'b0, b13} - {13'b0, bin13};
      start = 1'b1;
      tick();
      start = 1'b0;
      seen8 = 0;
      seen13 = 0;
      for (int c = 1; c <= 18; c++) begin
        if (done8 && !seen8) begin
          seen8 = 1;
          check("sw8_cycle", c, 9);
          check("sw8_diff", diff8, r8[7:0]);
          check("sw8_bout", bout8, r8[8]);
        end
        if (done13 && !seen13) begin
          seen13 = 1;
          check("sw13_cycle", c, 14);
          check("sw13_diff", diff13, r13[12:0]);
          check("sw13_bout", bout13, r13[13]);
        end
        tick();
      end
      if (!seen8) check("sw8_timeout", 0, 1);
      if (!seen13) check("sw13_timeout", 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_full_subtractor.md
SERIAL_FULL_SUBTRACTOR -- requirements
Module: serial_full_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to load operands and begin a subtraction.
REQ-005 SHALL have port: a_in  input  WIDTH  minuend, sampled only when start is accepted.
REQ-006 SHALL have port: b_in  input  WIDTH  subtrahend, sampled only when start is accepted.
REQ-007 SHALL have port: bin  input  1  borrow-in, sampled only when start is accepted.
REQ-008 SHALL have port: busy  output  1  high in RUN and DONE states.
REQ-009 SHALL have port: diff_bit_valid  output  1  high for each cycle a serial difference bit is produced.
REQ-010 SHALL have port: diff_bit  output  1  serial difference bit, LSB first, qualified by diff_bit_valid.
REQ-011 SHALL have port: diff_out  output  WIDTH  parallel result a_in - b_in - bin mod 2^WIDTH.
REQ-012 SHALL have port: bout  output  1  final borrow-out (1 when a_in < b_in + bin).
REQ-013 SHALL have port: done  output  1  single-cycle pulse when diff_out/bout are final.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 SHALL accept start only in IDLE; start in RUN or DONE SHALL be ignored, with no effect on registers.
REQ-016 On accepted start at edge k: load a/b shift registers, borrow register <= bin, bit counter <= 0, clear diff_out, enter RUN.
REQ-017 In RUN, each cycle SHALL compute from current LSBs a, b and borrow br: d = a^b^br; br_next = (~a&b) | (~(a^b)&br).
REQ-018 In RUN, each cycle SHALL drive diff_bit = d with diff_bit_valid = 1, shift d into diff_out MSB (right shift), shift a/b right, update br, increment counter.
REQ-019 After WIDTH RUN cycles (counter = WIDTH-1 on the final RUN cycle), the FSM SHALL enter DONE; bout <= br_next of the final bit.
REQ-020 done SHALL be high for exactly the one DONE cycle (cycle k+WIDTH+1 relative to accepting edge k); the FSM then returns to IDLE.
REQ-021 diff_out and bout SHALL hold their final values in IDLE until the next accepted start.
REQ-022 diff_bit_valid SHALL be 0 outside RUN; diff_bit SHALL be 0 when diff_bit_valid is 0.
REQ-023 Total latency, accepted start to done: WIDTH+1 cycles; minimum start-to-start interval: WIDTH+2 cycles.
REQ-024 start asserted in the same cycle as done SHALL be ignored; start in the following (IDLE) cycle SHALL be accepted.

Reset
REQ-025 When rst is high at a clock edge, the FSM SHALL enter IDLE regardless of state, including mid-RUN; any in-flight operation is discarded.
REQ-026 Reset values: busy 0, diff_bit_valid 0, diff_bit 0, diff_out 0, bout 0, done 0, counter 0, borrow register 0.
REQ-027 rst SHALL take priority over start in the same cycle.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the WIDTH default constant.
REQ-029 The one-bit d/br_next logic SHALL be a sub-module half_subtractor instantiated twice (a-b, then result-br), borrows ORed, mirroring the two-half-adder full adder.
REQ-030 The counter SHALL be sized clog2(WIDTH) bits; no combinational path from start to any output.

Verification
REQ-031 WIDTH=8, a_in=8'h05, b_in=8'h03, bin=0 -> serial bits 0,1,0,0,0,0,0,0; diff_out=8'h02, bout=0, done 9 cycles after start.
REQ-032 a_in=8'h03, b_in=8'h05, bin=0 -> diff_out=8'hFE, bout=1.
REQ-033 a_in=8'h00, b_in=8'h00, bin=1 -> diff_out=8'hFF, bout=1; a_in=8'hFF, b_in=8'hFF, bin=0 -> diff_out=8'h00, bout=0.
REQ-034 start pulsed with new operands during RUN and again coincident with done -> both ignored, result unchanged; start one cycle after done accepted.
REQ-035 rst asserted on the 4th RUN cycle -> next cycle all outputs at reset values, no done pulse; a subsequent start completes correctly.
REQ-036 Randomised sweep, 1000 operand triples, WIDTH=8 and WIDTH=13, diff_out/bout compared against a_in - b_in - bin reference model.
